// File: rtl/vc_out_chan_allocator.sv
// rtl/vc_out_chan_allocator.sv - per-output-port packet-level round-robin VC allocator
// Optional macro FAST_REARB_EN: re-arbitrate on the tail transfer so grants need no idle cycle.
module vc_out_chan_allocator #(
  parameter int                   IN_N      = 5,
  parameter int                   SEL_W     = 3,
  parameter int                   FLIT_ID_W = 2,
  parameter logic [FLIT_ID_W-1:0] HEADER_ID = 2'b01,
  parameter logic [FLIT_ID_W-1:0] TAIL_ID   = 2'b10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [IN_N-1:0]           req_i,
  input  logic [IN_N*FLIT_ID_W-1:0] flit_id_i,
  input  logic [IN_N-1:0]           flit_vld_i,
  input  logic                      out_rdy_i,
  output logic [IN_N-1:0]           grant_o,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      xfer_o,
  output logic                      busy_o,
  output logic                      err_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IN_N-1:0]      grant_q, grant_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic                 first_q, first_d;
  logic                 err_q, err_d;
  logic                 cur_vld;
  logic [FLIT_ID_W-1:0] cur_id;
  logic                 xfer;
  logic [SEL_W-1:0]     pick;

  // Round-robin scan starting one past base, wrapping modulo IN_N.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [IN_N-1:0] req,
                                               input logic [SEL_W-1:0] base);
    logic [SEL_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= IN_N; k++) begin
      idx = (int'(base) + k) % IN_N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
    return win;
  endfunction

  always_comb begin
    cur_vld = 1'b0;
    cur_id  = '0;
    for (int i = 0; i < IN_N; i++) begin
      if (sel_q == SEL_W'(i)) begin
        cur_vld = flit_vld_i[i];
        cur_id  = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
      end
    end
  end

  assign xfer = (state_q == LOCKED) && cur_vld && out_rdy_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    err_d   = err_q;
    pick    = '0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          pick    = rr_pick(req_i, ptr_q);
          state_d = LOCKED;
          grant_d = IN_N'(1) << pick;
          sel_d   = pick;
          ptr_d   = pick;
          first_d = 1'b1;
        end
      end
      LOCKED: begin
        if (xfer) begin
          first_d = 1'b0;
          // Packets must open with a header and carry no further header.
          if (first_q && (cur_id != HEADER_ID)) err_d = 1'b1;
          if (!first_q && (cur_id == HEADER_ID)) err_d = 1'b1;
          if (cur_id == TAIL_ID) begin
`ifdef FAST_REARB_EN
            if (|(req_i & ~grant_q)) begin
              pick    = rr_pick(req_i & ~grant_q, sel_q);
              grant_d = IN_N'(1) << pick;
              sel_d   = pick;
              ptr_d   = pick;
              first_d = 1'b1;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
`else
            state_d = IDLE;
            grant_d = '0;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(IN_N - 1);
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign xfer_o  = xfer;
  assign busy_o  = (state_q == LOCKED);
  assign err_o   = err_q;

endmodule

// File: tb/tb_vc_out_chan_allocator.sv
// tb/tb_vc_out_chan_allocator.sv - self-checking bench for vc_out_chan_allocator
module tb_vc_out_chan_allocator;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] T = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [9:0] ids;
  logic [4:0] vld;
  logic       rdy;
  wire  [4:0] grant;
  wire  [2:0] sel;
  wire        xfer, busy, err;
  wire [10:0] obs = {grant, sel, busy, xfer, err};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: locked VC (-1 when free), pointer, last select, header-expected flag, error.
  int m_vc, m_ptr, m_sel;
  bit m_first, m_err;

  vc_out_chan_allocator dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .flit_id_i(ids), .flit_vld_i(vld),
    .out_rdy_i(rdy), .grant_o(grant), .sel_o(sel), .xfer_o(xfer), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic int scan(int p, logic [4:0] r);
    for (int k = 1; k <= 5; k++)
      if (r[(p + k) % 5]) return (p + k) % 5;
    return -1;
  endfunction

  function automatic logic [10:0] expv();
    logic [4:0] g;
    logic       x;
    g = (m_vc >= 0) ? (5'(1) << m_vc) : 5'b0;
    x = (m_vc >= 0) && vld[m_vc] && rdy;
    return {g, 3'(m_sel), m_vc >= 0, x, m_err};
  endfunction

  task automatic model_step();
    int         w;
    logic [1:0] id;
    if (!rst_n) begin
      m_vc = -1; m_ptr = 4; m_sel = 0; m_first = 0; m_err = 0;
      return;
    end
    if (m_vc < 0) begin
      w = scan(m_ptr, req);
      if (w >= 0) begin m_vc = w; m_ptr = w; m_sel = w; m_first = 1; end
    end else if (vld[m_vc] && rdy) begin
      id = ids[m_vc*2 +: 2];
      if (m_first != (id == H)) m_err = 1;
      m_first = 0;
      if (id == T) begin
`ifdef FAST_REARB_EN
        w = scan(m_vc, req & ~(5'(1) << m_vc));
`else
        w = -1;
`endif
        m_vc = w;
        if (w >= 0) begin m_ptr = w; m_sel = w; m_first = 1; end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] r, input logic [9:0] i, input logic [4:0] v, input logic rd);
    req = r; ids = i; vld = v; rdy = rd;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(5'b0, 10'b0, 5'b0, 1'b1);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'b11111, {5{H}}, 5'b11111, 1'b1);
    tick();
    tick();
    n_checks++;
    if (obs !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b exp %b", obs, 11'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [1:0] seq [3] = '{H, B, T};
    do_reset();
    drive(5'b00001, {5{H}}, 5'b0, 1'b1);
    n_checks++;
    if (grant !== 5'b0) begin n_fail++; $display("FAIL single_latency: got %b exp 00000", grant); end
    tick();
    for (int f = 0; f < 3; f++) begin
      drive(5'b0, {5{seq[f]}}, 5'b00001, 1'b1);
      n_checks++;
      if (grant !== 5'b00001 || xfer !== 1'b1 || obs !== expv()) begin
        n_fail++;
        $display("FAIL single_flit%0d: got %b exp %b", f, obs, expv());
      end
      tick();
    end
    drive(5'b0, {5{B}}, 5'b0, 1'b1);
    n_checks++;
    if (grant !== 5'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: got grant=%b busy=%b err=%b exp 00000 0 0", grant, busy, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] order [4];
    logic [4:0] exp_order [4] = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
    logic [4:0] prev = 5'b0;
    int         n = 0;
    do_reset();
    for (int c = 0; c < 40 && n < 4; c++) begin
      drive(5'b10110, {5{(m_vc >= 0 && m_first) ? H : T}}, 5'b11111, 1'b1);
      n_checks++;
      if (obs !== expv()) begin n_fail++; $display("FAIL rr_cycle%0d: got %b exp %b", c, obs, expv()); end
      if (grant !== 5'b0 && grant !== prev) begin order[n] = grant; n++; end
      prev = grant;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= n || order[k] !== exp_order[k]) begin
        n_fail++;
        $display("FAIL rr_order%0d: got %b exp %b", k, (k < n) ? order[k] : 5'b0, exp_order[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(5'b00100, {5{H}}, 5'b0, 1'b1);
    tick();
    drive(5'b0, {5{H}}, 5'b00100, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(5'b00001, {5{T}}, 5'b00100, 1'b0);
      n_checks++;
      if (xfer !== 1'b0 || grant !== 5'b00100 || sel !== 3'd2 || obs !== expv()) begin
        n_fail++;
        $display("FAIL stall%0d: got %b exp %b", c, obs, expv());
      end
      tick();
    end
    drive(5'b0, {5{T}}, 5'b00100, 1'b1);
    n_checks++;
    if (xfer !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got xfer=%b exp 1", xfer); end
    tick();
    drive(5'b0, {5{B}}, 5'b0, 1'b1);
    n_checks++;
    if (grant !== 5'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got grant=%b err=%b exp 00000 0", grant, err);
    end
  endtask

  task automatic test_header_error();
    do_reset();
    drive(5'b00001, {5{H}}, 5'b0, 1'b1);
    tick();
    drive(5'b0, {5{B}}, 5'b00001, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(5'b0, {5{T}}, (c == 0) ? 5'b00001 : 5'b0, 1'b1);
      n_checks++;
      if (err !== 1'b1 || obs !== expv()) begin
        n_fail++;
        $display("FAIL err_sticky%0d: got %b exp %b", c, obs, expv());
      end
      tick();
    end
    do_reset();
    drive(5'b0, {5{B}}, 5'b0, 1'b1);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b exp 0", err); end
  endtask

  task automatic test_fast_rearb();
    do_reset();
    drive(5'b01001, {5{H}}, 5'b0, 1'b1);
    tick();
    drive(5'b01000, {5{H}}, 5'b00001, 1'b1);
    tick();
    drive(5'b01000, {5{T}}, 5'b00001, 1'b1);
    tick();
    drive(5'b01000, {5{H}}, 5'b0, 1'b1);
`ifdef FAST_REARB_EN
    n_checks++;
    if (grant !== 5'b01000 || obs !== expv()) begin
      n_fail++;
      $display("FAIL fast_rearb: got %b exp grant 01000", grant);
    end
`else
    n_checks++;
    if (grant !== 5'b0 || obs !== expv()) begin
      n_fail++;
      $display("FAIL rearb_bubble: got %b exp 00000", grant);
    end
    tick();
    drive(5'b01000, {5{H}}, 5'b0, 1'b1);
    n_checks++;
    if (grant !== 5'b01000) begin n_fail++; $display("FAIL rearb_next: got %b exp 01000", grant); end
`endif
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(5'b00100, {5{H}}, 5'b0, 1'b1);
    tick();
    drive(5'b0, {5{H}}, 5'b00100, 1'b1);
    tick();
    rst_n = 1'b0;
    drive(5'b0, {5{B}}, 5'b00100, 1'b1);
    tick();
    n_checks++;
    if (grant !== 5'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got grant=%b busy=%b exp 00000 0", grant, busy);
    end
    rst_n = 1'b1;
    drive(5'b11111, {5{H}}, 5'b0, 1'b1);
    tick();
    drive(5'b0, {5{H}}, 5'b0, 1'b1);
    n_checks++;
    if (grant !== 5'b00001 || sel !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_ptr: got grant=%b sel=%0d exp 00001 0", grant, sel);
    end
  endtask

  task automatic test_random();
    logic [9:0] r_ids;
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 80) != 0);
      for (int i = 0; i < 5; i++) r_ids[i*2 +: 2] = 2'($urandom_range(0, 3));
      drive(5'($urandom), r_ids, 5'($urandom), $urandom_range(0, 3) != 0);
      n_checks++;
      if (obs !== expv()) begin n_fail++; $display("FAIL random%0d: got %b exp %b", c, obs, expv()); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; ids = '0; vld = '0; rdy = 1'b1;
    m_vc = -1; m_ptr = 4; m_sel = 0; m_first = 0; m_err = 0;
    @(negedge clk);
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_backpressure();
    test_header_error();
    test_fast_rearb();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
